// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with press/release debounce and key encoder.
// Optional ctrl auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_debounce #(
    parameter int unsigned SCAN_CYCLES     = 27000,
    parameter int unsigned DEBOUNCE_CYCLES = 540000,
    parameter int unsigned REPEAT_CYCLES   = 13500000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] columnas,
    input  logic [3:0] filas,
    output logic [3:0] boton,
    output logic       ctrl
);

    localparam int unsigned CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    if (SCAN_CYCLES < 4 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("keypad_scan_debounce: parameter out of range");
    end

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } state_t;

    state_t        state_q;
    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    col_q;
    logic [1:0]    row_q;
    logic [3:0]    boton_q;
    logic          ctrl_q;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_q;
`endif

    logic [3:0] rs;
    logic [1:0] low_row_d;
    logic [1:0] col_idx_d;
    logic [3:0] col_next_d;
    logic [3:0] key_code_d;
    logic       row_up_d;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hD;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hE;
            default:  code = 4'hF;
        endcase
        return code;
    endfunction

    always_comb begin
        rs = sync2_q;
        row_up_d = rs[row_q];
        col_next_d = {col_q[2:0], col_q[3]};
        key_code_d = key_code(row_q, col_idx_d);
    end

    // Lowest-index low row wins when several rows are pulled down together.
    always_comb begin
        low_row_d = 2'd3;
        if (!rs[0]) begin
            low_row_d = 2'd0;
        end else if (!rs[1]) begin
            low_row_d = 2'd1;
        end else if (!rs[2]) begin
            low_row_d = 2'd2;
        end
    end

    always_comb begin
        case (col_q)
            4'b1101: col_idx_d = 2'd1;
            4'b1011: col_idx_d = 2'd2;
            4'b0111: col_idx_d = 2'd3;
            default: col_idx_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN;
            sync1_q <= '1;
            sync2_q <= '1;
            cnt_q   <= '0;
            col_q   <= 4'b1110;
            row_q   <= '0;
            boton_q <= '0;
            ctrl_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            sync1_q <= filas;
            sync2_q <= sync1_q;
            case (state_q)
                SCAN: begin
                    if (cnt_q == SCAN_LAST) begin
                        cnt_q <= '0;
                        if (rs != 4'hF) begin
                            row_q   <= low_row_d;
                            state_q <= DEB_PRESS;
                        end else begin
                            col_q <= col_next_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (row_up_d) begin
                        state_q <= SCAN;
                        col_q   <= col_next_d;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        boton_q <= key_code_d;
                        ctrl_q  <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_q   <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (row_up_d) begin
                        state_q <= DEB_RELEASE;
                        cnt_q   <= '0;
                        ctrl_q  <= 1'b1;
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        // One-clock ctrl drop gives the entry logic a fresh rising edge.
                        if (rep_q == REP_LAST) begin
                            rep_q  <= '0;
                            ctrl_q <= 1'b0;
                        end else begin
                            rep_q  <= rep_q + 1'b1;
                            ctrl_q <= 1'b1;
                        end
`else
                        ctrl_q <= 1'b1;
`endif
                    end
                end
                DEB_RELEASE: begin
                    if (!row_up_d) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                        ctrl_q  <= 1'b0;
                        col_q   <= col_next_d;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_q   <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= SCAN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign columnas = col_q;
    assign boton    = boton_q;
    assign ctrl     = ctrl_q;

endmodule
